opl3_reg_wr_arbiter: RTL and testbench
======================================

Name: opl3_reg_wr_arbiter

Overview:
- Shares the single opl3_reg_wr register-write port between two requesters: host bus interface (req 0) and on-chip playback engine (req 1).
- Enforces a minimum spacing between issued writes.
- Holds back writes to channel-mix registers while the channel accumulation pass is running, so one sample never mixes old and new routing. Writes to those registers are bank 0/1 0xC0-0xC8, bank 1 0x04/0x05 and bank 0 0xBD.
- Sits between the bus/playback logic and the register consumers: operators, channels and timers.

Parameters:
- MIN_WR_GAP, 4, minimum clk cycles from one issued write to the next (1..255; 1 = back-to-back allowed).
- HOLD_MIX_WRITES, 1, 1 = enable the mix-register blackout during accumulation; 0 = never hold.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  2  per-requester write request; bit i = requester i
- req_ready  out  2  per-requester accept; a write transfers when req_valid[i] && req_ready[i]
- req_bank_num  in  2x1  bank per requester
- req_address  in  2x8  register address per requester
- req_data  in  2xREG_FILE_DATA_WIDTH  write data per requester
- sample_clk_en  in  1  start-of-sample strobe
- ops_done_pulse  in  1  operator pass complete; channel accumulation starts
- channel_valid  in  1  channel accumulation complete, sample latched
- opl3_reg_wr  out  opl3_reg_wr_t  issued write {valid, bank_num, address, data}
- mix_hold  out  1  high while accumulation is in progress and mix writes are held
- held_count  out  16  saturating count of cycles a mix write was stalled by the blackout (debug)

Behaviour:
- Reset (reset_n low, async): opl3_reg_wr all zero, req_ready=0, mix_hold=0, held_count=0, gap counter=0, round-robin pointer=0 (req 0 favoured), accum_busy=0.
- accum_busy register:
  - Set on ops_done_pulse.
  - Cleared on channel_valid or sample_clk_en.
  - If set and clear occur in the same cycle, clear wins.
  - mix_hold = accum_busy && HOLD_MIX_WRITES.
- is_mix(bank, addr) is true for any of: addr 0xC0..0xC8 (either bank); bank 1 && addr 0x04; bank 1 && addr 0x05; bank 0 && addr 0xBD.
- eligible[i] = req_valid[i] && !(mix_hold && is_mix(i)) && gap_cnt==0.
- Arbitration, registered and single-cycle:
  - If exactly one requester is eligible, grant it.
  - If both are eligible, grant the requester pointed to by the RR pointer. The pointer then moves to the other requester.
  - A pointer move happens only on a grant.
- req_ready is combinational from the registered state: req_ready[i]=1 exactly in the cycle requester i is granted. At most one bit of req_ready is high per cycle.
- Issue timing: opl3_reg_wr.valid=1 for exactly one cycle, the cycle after the handshake, carrying the captured bank/address/data. Latency is 1 cycle, handshake to valid.
- Gap counter:
  - Loaded with MIN_WR_GAP-1 on each grant.
  - Decrements to 0, then holds.
  - MIN_WR_GAP=1 allows a grant every cycle.
- Requester obligations: req_bank_num/address/data stay stable while req_valid is high and not yet accepted. Dropping req_valid without acceptance is legal; the request is discarded.
- A held mix write does not block the other requester. If req 1 is held and req 0 has a non-mix write, req 0 is granted.
- held_count: +1 per cycle in which some req_valid[i] && mix_hold && is_mix(i) && gap_cnt==0. Saturates at 0xFFFF.
- Reset mid-operation: a pending opl3_reg_wr.valid is cleared immediately and the write is lost. Requesters must re-present after reset.
- sample_clk_en concurrent with ops_done_pulse: accum_busy=0 (clear wins).

Test Plan:
- Single write: req 0 valid, bank 0, addr 0x20, data 0x21, gap 0.
  - req_ready[0] high in the same cycle.
  - Next cycle opl3_reg_wr = {1,0,0x20,0x21}.
  - Valid for exactly 1 cycle.
- Contention with MIN_WR_GAP=4: both requesters continuously valid with non-mix writes from reset.
  - Grants alternate 0,1,0,1, spaced exactly 4 cycles apart.
  - opl3_reg_wr.valid never closer than 4 cycles.
- Blackout, with HOLD_MIX_WRITES=1:
  - Pulse ops_done_pulse, then present req 1 bank 1 addr 0x04 data 0x3F.
  - No grant while mix_hold=1; held_count increments each stalled cycle.
  - After channel_valid, granted within 1 cycle.
- Blackout bypass: during mix_hold, req 0 presents addr 0xA0 while req 1 presents 0xC3.
  - req 0 granted immediately.
  - req 1 waits for channel_valid.
- Clear priority: ops_done_pulse and sample_clk_en in the same cycle.
  - mix_hold stays 0.
  - A 0xBD bank 0 write is granted without stall.
- Async reset: assert reset_n low in the cycle opl3_reg_wr.valid=1.
  - Outputs zero immediately, without a clk edge.
  - held_count=0.
  - After release, the first grant goes to req 0 when both are valid.

Source files
------------

// File: rtl/opl3_reg_wr_arbiter.sv
// Shares the OPL3 register-write port between the host bus (req 0) and the playback engine (req 1),
// spacing issued writes and holding channel-mix writes back while channel accumulation runs.
package opl3_reg_wr_arbiter_pkg;

    localparam int REG_FILE_DATA_WIDTH = 8;

    typedef struct packed {
        logic                           valid;
        logic                           bank_num;
        logic [7:0]                     address;
        logic [REG_FILE_DATA_WIDTH-1:0] data;
    } opl3_reg_wr_t;

endpackage

module opl3_reg_wr_arbiter
    import opl3_reg_wr_arbiter_pkg::*;
#(
    parameter int unsigned MIN_WR_GAP      = 4,   // 1..255, 1 = back-to-back writes
    parameter bit          HOLD_MIX_WRITES = 1'b1
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic [1:0]                           req_valid,
    output logic [1:0]                           req_ready,
    input  logic [1:0]                           req_bank_num,
    input  logic [1:0][7:0]                      req_address,
    input  logic [1:0][REG_FILE_DATA_WIDTH-1:0]  req_data,
    input  logic                                 sample_clk_en,
    input  logic                                 ops_done_pulse,
    input  logic                                 channel_valid,
    output opl3_reg_wr_t                         opl3_reg_wr,
    output logic                                 mix_hold,
    output logic [15:0]                          held_count
);

    localparam logic [7:0] GAP_LOAD = 8'(MIN_WR_GAP - 1);

    logic [7:0] gap_cnt;
    logic       rr_ptr;
    logic       accum_busy;
    logic       gap_open;
    logic [1:0] blocked;
    logic [1:0] eligible;
    logic [1:0] stalled;
    logic [1:0] grant;
    logic       grant_idx;

    // Registers that change channel output routing or mixing.
    function automatic logic is_mix(input logic bank, input logic [7:0] addr);
        return (addr >= 8'hC0 && addr <= 8'hC8)
            || (bank && (addr == 8'h04 || addr == 8'h05))
            || (!bank && addr == 8'hBD);
    endfunction

    assign mix_hold = accum_busy & HOLD_MIX_WRITES;
    assign gap_open = (gap_cnt == 8'd0);

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            blocked[i]  = mix_hold && is_mix(req_bank_num[i], req_address[i]);
            eligible[i] = req_valid[i] && !blocked[i] && gap_open;
            stalled[i]  = req_valid[i] && blocked[i] && gap_open;
        end
    end

    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    always_comb begin
        grant = 2'b00;
        case (eligible)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = rr_ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
        // Nothing is accepted while reset is asserted, even with requests pending.
        if (!reset_n) grant = 2'b00;
    end

    assign req_ready = grant;
    assign grant_idx = grant[1];

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            opl3_reg_wr <= '0;
            gap_cnt     <= 8'd0;
            rr_ptr      <= 1'b0;
        end else if (grant != 2'b00) begin
            opl3_reg_wr <= '{valid:    1'b1,
                             bank_num: req_bank_num[grant_idx],
                             address:  req_address[grant_idx],
                             data:     req_data[grant_idx]};
            gap_cnt     <= GAP_LOAD;
            rr_ptr      <= ~grant_idx;
        end else begin
            opl3_reg_wr.valid <= 1'b0;
            if (!gap_open) gap_cnt <= gap_cnt - 8'd1;
        end
    end

    // Clear wins over set so a new sample never starts with a stale blackout.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            accum_busy <= 1'b0;
        end else if (channel_valid || sample_clk_en) begin
            accum_busy <= 1'b0;
        end else if (ops_done_pulse) begin
            accum_busy <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            held_count <= 16'd0;
        end else if ((|stalled) && held_count != 16'hFFFF) begin
            held_count <= held_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_opl3_reg_wr_arbiter.sv
// Randomized and directed bench for opl3_reg_wr_arbiter: two instances with different parameters
// are compared every cycle against a cycle-time reference model.
module tb_opl3_reg_wr_arbiter;
    import opl3_reg_wr_arbiter_pkg::*;

    localparam int DW = REG_FILE_DATA_WIDTH;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [1:0]          req_valid;
    logic [1:0]          req_bank_num;
    logic [1:0][7:0]     req_address;
    logic [1:0][DW-1:0]  req_data;
    logic                sample_clk_en;
    logic                ops_done_pulse;
    logic                channel_valid;

    logic [1:0]          ready_a, ready_b;
    opl3_reg_wr_t        wr_a, wr_b;
    logic                hold_a, hold_b;
    logic [15:0]         held_a, held_b;

    always #5 clk = ~clk;

    opl3_reg_wr_arbiter #(.MIN_WR_GAP(4), .HOLD_MIX_WRITES(1'b1)) dut_a (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(ready_a),
        .req_bank_num(req_bank_num), .req_address(req_address), .req_data(req_data),
        .sample_clk_en(sample_clk_en), .ops_done_pulse(ops_done_pulse), .channel_valid(channel_valid),
        .opl3_reg_wr(wr_a), .mix_hold(hold_a), .held_count(held_a)
    );

    opl3_reg_wr_arbiter #(.MIN_WR_GAP(1), .HOLD_MIX_WRITES(1'b0)) dut_b (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(ready_b),
        .req_bank_num(req_bank_num), .req_address(req_address), .req_data(req_data),
        .sample_clk_en(sample_clk_en), .ops_done_pulse(ops_done_pulse), .channel_valid(channel_valid),
        .opl3_reg_wr(wr_b), .mix_hold(hold_b), .held_count(held_b)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: spacing kept as the absolute cycle of the next allowed write.
    int           gap_p  [2] = '{4, 1};
    bit           hold_p [2] = '{1'b1, 1'b0};
    bit           m_busy [2];
    int           m_ptr  [2];
    longint       m_next [2];
    int           m_held [2];
    opl3_reg_wr_t m_wr   [2];
    logic [1:0]   g_m    [2];
    longint       cyc = 0;
    logic [1:0]   obs_ready_a;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit mix_reg(input logic bank, input logic [7:0] addr);
        return (addr >= 8'hC0 && addr <= 8'hC8) || (bank && (addr == 8'h04 || addr == 8'h05))
            || (!bank && addr == 8'hBD);
    endfunction

    function automatic logic [1:0] model_grant(input int k);
        logic [1:0] el;
        bit hold = m_busy[k] && hold_p[k];
        for (int i = 0; i < 2; i++)
            el[i] = req_valid[i] && !(hold && mix_reg(req_bank_num[i], req_address[i])) && (cyc >= m_next[k]);
        if (!reset_n) return 2'b00;
        if (el == 2'b11) return (m_ptr[k] == 0) ? 2'b01 : 2'b10;
        return el;
    endfunction

    function automatic bit model_stalled(input int k);
        bit s = 1'b0;
        for (int i = 0; i < 2; i++)
            if (req_valid[i] && m_busy[k] && hold_p[k] && mix_reg(req_bank_num[i], req_address[i]) && cyc >= m_next[k])
                s = 1'b1;
        return s;
    endfunction

    task automatic reset_model();
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 1'b0;
            m_ptr[k]  = 0;
            m_next[k] = cyc;
            m_held[k] = 0;
            m_wr[k]   = '0;
            g_m[k]    = 2'b00;
        end
    endtask

    // One clock: check combinational accept, advance, then check registered outputs.
    task automatic step();
        logic [1:0] g [2];
        bit st [2];
        int idx;
        #1;
        for (int k = 0; k < 2; k++) begin
            g[k]  = model_grant(k);
            st[k] = model_stalled(k);
        end
        obs_ready_a = ready_a;
        check("req_ready_a", ready_a, g[0]);
        check("req_ready_b", ready_b, g[1]);
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (g[k] != 2'b00) begin
                idx = g[k][1] ? 1 : 0;
                m_wr[k].valid    = 1'b1;
                m_wr[k].bank_num = req_bank_num[idx];
                m_wr[k].address  = req_address[idx];
                m_wr[k].data     = req_data[idx];
                m_next[k] = cyc + gap_p[k];
                m_ptr[k]  = 1 - idx;
            end else begin
                m_wr[k].valid = 1'b0;
            end
            if (st[k] && m_held[k] < 65535) m_held[k]++;
            if (channel_valid || sample_clk_en) m_busy[k] = 1'b0;
            else if (ops_done_pulse)            m_busy[k] = 1'b1;
            g_m[k] = g[k];
        end
        cyc++;
        #1;
        check("wr_a", wr_a, m_wr[0]);
        check("wr_b", wr_b, m_wr[1]);
        check("mix_hold_a", hold_a, m_busy[0] && hold_p[0]);
        check("mix_hold_b", hold_b, m_busy[1] && hold_p[1]);
        check("held_a", held_a, 64'(m_held[0]));
        check("held_b", held_b, 64'(m_held[1]));
    endtask

    task automatic quiet_inputs();
        req_valid      = 2'b00;
        sample_clk_en  = 1'b0;
        ops_done_pulse = 1'b0;
        channel_valid  = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        quiet_inputs();
        reset_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic idle(input int n);
        quiet_inputs();
        repeat (n) step();
    endtask

    function automatic logic [7:0] pick_addr();
        case ($urandom_range(0, 6))
            0:       return 8'h04;
            1:       return 8'h05;
            2:       return 8'hBD;
            3:       return 8'hC0 + 8'($urandom_range(0, 9));
            4:       return 8'hA0;
            5:       return 8'hBF;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        int last_cyc;
        int last_idx;
        int grants;
        int h0;

        // Reset state, with requests already pending.
        reset_n        = 1'b0;
        quiet_inputs();
        req_valid      = 2'b11;
        req_bank_num   = 2'b00;
        req_address    = {8'h40, 8'h20};
        req_data       = '0;
        #1;
        check("reset_ready", ready_a, 2'b00);
        check("reset_wr", wr_a, 0);
        check("reset_hold", hold_a, 0);
        check("reset_held", held_a, 0);
        do_reset();

        // Single write: accepted immediately, issued once, one cycle later.
        req_valid      = 2'b01;
        req_bank_num   = 2'b00;
        req_address[0] = 8'h20;
        req_data[0]    = 8'h21;
        step();
        check("single_ready", obs_ready_a, 2'b01);
        check("single_wr", wr_a, {1'b1, 1'b0, 8'h20, 8'h21});
        req_valid = 2'b00;
        step();
        check("single_pulse", wr_a.valid, 0);
        idle(4);

        // Contention from reset: alternating grants exactly MIN_WR_GAP apart.
        do_reset();
        req_valid      = 2'b11;
        req_bank_num   = 2'b10;
        req_address    = {8'h40, 8'h20};
        req_data       = {8'h55, 8'hAA};
        last_cyc = -1; last_idx = -1; grants = 0;
        repeat (17) begin
            step();
            if (obs_ready_a != 2'b00) begin
                if (last_cyc < 0) check("cont_first", obs_ready_a, 2'b01);
                else begin
                    check("cont_spacing", 64'(int'(cyc) - 1 - last_cyc), 4);
                    check("cont_alternate", obs_ready_a[1], 64'(1 - last_idx));
                end
                last_cyc = int'(cyc) - 1;
                last_idx = obs_ready_a[1] ? 1 : 0;
                grants++;
            end
        end
        check("cont_grants", grants, 5);
        idle(4);

        // Blackout: mix write from req 1 stalls until channel_valid.
        ops_done_pulse = 1'b1;
        step();
        ops_done_pulse  = 1'b0;
        req_valid       = 2'b10;
        req_bank_num[1] = 1'b1;
        req_address[1]  = 8'h04;
        req_data[1]     = 8'h3F;
        h0 = int'(held_a);
        repeat (6) begin
            step();
            check("blackout_no_grant", obs_ready_a, 2'b00);
        end
        check("blackout_held_inc", 64'(int'(held_a) - h0), 6);
        channel_valid = 1'b1;
        step();
        channel_valid = 1'b0;
        step();
        check("blackout_release", obs_ready_a, 2'b10);
        idle(4);

        // Bypass: non-mix write from req 0 proceeds past a held mix write from req 1.
        ops_done_pulse = 1'b1;
        step();
        ops_done_pulse = 1'b0;
        req_valid      = 2'b11;
        req_bank_num   = 2'b00;
        req_address    = {8'hC3, 8'hA0};
        step();
        check("bypass_req0", obs_ready_a, 2'b01);
        req_valid = 2'b10;
        repeat (5) step();
        check("bypass_req1_wait", obs_ready_a, 2'b00);
        channel_valid = 1'b1;
        step();
        channel_valid = 1'b0;
        step();
        check("bypass_req1_release", obs_ready_a, 2'b10);
        idle(4);

        // Clear wins when ops_done_pulse and sample_clk_en coincide.
        ops_done_pulse = 1'b1;
        sample_clk_en  = 1'b1;
        step();
        check("clear_prio_hold", hold_a, 0);
        quiet_inputs();
        req_valid      = 2'b01;
        req_bank_num   = 2'b00;
        req_address[0] = 8'hBD;
        step();
        check("clear_prio_grant", obs_ready_a, 2'b01);
        idle(4);

        // Randomized traffic obeying the hold-while-pending rule.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && (g_m[0][i] || g_m[1][i])) req_valid[i] = 1'b0;
                else if (req_valid[i]) begin
                    if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
                end else if ($urandom_range(0, 1) == 1) begin
                    req_valid[i]    = 1'b1;
                    req_bank_num[i] = 1'($urandom);
                    req_address[i]  = pick_addr();
                    req_data[i]     = DW'($urandom);
                end
            end
            ops_done_pulse = ($urandom_range(0, 7) == 0);
            channel_valid  = ($urandom_range(0, 15) == 0);
            sample_clk_en  = ($urandom_range(0, 31) == 0);
            step();
        end
        idle(4);

        // Async reset while a write is being issued; pointer left favouring req 1.
        req_valid      = 2'b01;
        req_bank_num   = 2'b00;
        req_address[0] = 8'h20;
        ops_done_pulse = 1'b1;
        step();
        quiet_inputs();
        req_valid = 2'b10;
        req_bank_num[1] = 1'b1;
        req_address[1]  = 8'h05;
        step();
        check("areset_pre_held", (held_a != 16'd0), 1);
        req_valid      = 2'b01;
        req_address[0] = 8'h20;
        repeat (3) step();
        check("areset_pre_valid", wr_a.valid, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("areset_wr", wr_a, 0);
        check("areset_ready", ready_a, 2'b00);
        check("areset_hold", hold_a, 0);
        check("areset_held", held_a, 0);
        do_reset();
        req_valid      = 2'b11;
        req_bank_num   = 2'b00;
        req_address    = {8'h40, 8'h20};
        step();
        check("areset_first_grant", obs_ready_a, 2'b01);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
